mmio_responder: RTL

- Memory-mapped I/O target that answers the core's data-side load/store traffic, i.e. the responder end of the data-memory interface.
- Same timing contract as the synchronous data RAM: address, data and wren are sampled on the clock edge, and q is valid one cycle later.
- Owns the board I/O: synchronises and debounces KEY/SW, keeps a sticky KEY-press capture register, holds the LED/HEX output registers, and runs a free-running cycle timer.
- Sits beside the data RAM; the enclosing data-memory block muxes q using hit.

---
 rtl/mmio_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mmio_responder.sv
// ----------------------------------------------------------------------------
// mmio_responder : memory-mapped board I/O target beside the data RAM
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mmio_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0400,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        wren,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic        hit,
  input  logic [13:0] io_input_bus,
  output logic [51:0] io_output_bus
);

  localparam int                   c_presc_w    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(DEBOUNCE_CYCLES - 1);
  // KEY bits idle high (released), SW bits idle low
  localparam logic [13:0]          c_db_reset   = {4'hF, 10'h000};

  localparam logic [2:0] c_reg_led    = 3'd0;
  localparam logic [2:0] c_reg_hex_lo = 3'd1;
  localparam logic [2:0] c_reg_hex_hi = 3'd2;
  localparam logic [2:0] c_reg_sw     = 3'd3;
  localparam logic [2:0] c_reg_key    = 3'd4;
  localparam logic [2:0] c_reg_edge   = 3'd5;
  localparam logic [2:0] c_reg_timer  = 3'd6;
  localparam logic [2:0] c_reg_rsvd   = 3'd7;

  logic [13:0]          r_sync1;
  logic [13:0]          r_sync2;
  logic [13:0]          r_prev;
  logic [13:0]          r_db;
  logic [c_presc_w-1:0] r_presc;
  logic [9:0]           r_led;
  logic [5:0][6:0]      r_hex;
  logic [3:0]           r_key_edge;
  logic [31:0]          r_timer;

  logic [29:0] w_off;
  logic [2:0]  w_idx;
  logic        w_mapped;
  logic        w_wr;
  logic        w_tick;
  logic [13:0] w_stable;
  logic [13:0] w_db_next;
  logic [3:0]  w_key_set;
  logic [3:0]  w_key_clr;
  logic [31:0] w_rdata;
  logic [1:0]  w_unused_addr_bits;

  assign w_unused_addr_bits = address[1:0];

  always_comb begin
    w_off     = address[31:2] - BASE_ADDR[31:2];
    w_idx     = w_off[2:0];
    w_mapped  = (w_off[29:3] == '0) && (w_idx != c_reg_rsvd);
    w_wr      = wren && w_mapped;
    w_tick    = (r_presc == c_presc_last);
    // A bit only moves when two consecutive tick samples agree
    w_stable  = ~(r_sync2 ^ r_prev);
    w_db_next = w_tick ? ((r_sync2 & w_stable) | (r_db & ~w_stable)) : r_db;
    w_key_set = r_db[13:10] & ~w_db_next[13:10];
    w_key_clr = (w_wr && (w_idx == c_reg_edge)) ? data[3:0] : 4'h0;

    w_rdata = '0;
    case (w_idx)
      c_reg_led:    w_rdata = {22'd0, r_led};
      c_reg_hex_lo: w_rdata = {1'b0, r_hex[3], 1'b0, r_hex[2], 1'b0, r_hex[1], 1'b0, r_hex[0]};
      c_reg_hex_hi: w_rdata = {16'd0, 1'b0, r_hex[5], 1'b0, r_hex[4]};
      c_reg_sw:     w_rdata = {22'd0, r_db[9:0]};
      c_reg_key:    w_rdata = {28'd0, ~r_db[13:10]};
      c_reg_edge:   w_rdata = {28'd0, r_key_edge};
      c_reg_timer:  w_rdata = r_timer;
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= c_db_reset;
      r_db       <= c_db_reset;
      r_presc    <= '0;
      r_led      <= '0;
      r_hex      <= {6{7'h7F}};
      r_key_edge <= '0;
      r_timer    <= '0;
      q          <= '0;
      hit        <= 1'b0;
    end else begin
      r_sync1    <= io_input_bus;
      r_sync2    <= r_sync1;
      r_presc    <= w_tick ? '0 : r_presc + c_presc_w'(1);
      if (w_tick) begin
        r_prev <= r_sync2;
      end
      r_db       <= w_db_next;
      // Set is OR'd after the clear mask so a same-edge press survives
      r_key_edge <= (r_key_edge & ~w_key_clr) | w_key_set;
      q          <= w_mapped ? w_rdata : '0;
      hit        <= w_mapped;

      if (w_wr) begin
        case (w_idx)
          c_reg_led: r_led <= data[9:0];
          c_reg_hex_lo: begin
            r_hex[0] <= data[6:0];
            r_hex[1] <= data[14:8];
            r_hex[2] <= data[22:16];
            r_hex[3] <= data[30:24];
          end
          c_reg_hex_hi: begin
            r_hex[4] <= data[6:0];
            r_hex[5] <= data[14:8];
          end
          default: ;
        endcase
      end

      r_timer <= (w_wr && (w_idx == c_reg_timer)) ? data : r_timer + 32'd1;
    end
  end

  assign io_output_bus = {r_hex, r_led};

endmodule

`default_nettype wire
